// File: rtl/div_sequencer.sv
// ============================================================================
// Module   : div_sequencer
// Purpose  : Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer. It performs
//            restoring division, one quotient bit per cycle, on a shared
//            32-bit add/subtract unit in the execute stage.
// Ports    : clk, rst_n         - clock, synchronous active-low reset
//            start, op          - request and funct3[1:0] (00 DIV, 01 DIVU,
//                                 10 REM, 11 REMU), sampled in IDLE
//            rs1, rs2           - dividend and divisor, sampled with start
//            flush              - synchronous abort
//            busy, done, result - status, one-cycle done pulse, result
//            au_a, au_b, au_as  - drive to the shared add/sub unit
//            au_s, au_c         - sum and carry-out back from the unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module div_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] au_a,
  output logic [31:0] au_b,
  output logic        au_as,
  input  logic [31:0] au_s,
  input  logic        au_c
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [31:0] C_INT_MIN = 32'h8000_0000;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] quo_q, quo_d;      // dividend shifting out / quotient shifting in
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [31:0] dvs_q, dvs_d;      // divisor magnitude
  logic [4:0]  count_q, count_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Remainder shifted left by one with the next dividend bit brought in.
  logic [31:0] rem_shift;
  logic        take;
  logic        is_signed;
  logic        a_neg;
  logic        b_neg;

  assign rem_shift = {rem_q[30:0], quo_q[31]};
  // rem_q[31] is bit 32 of the 33-bit shifted remainder: when set the
  // shifted value is certainly >= divisor, and the low 32 bits of the
  // subtraction are still the correct new remainder.
  assign take      = rem_q[31] | au_c;
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & quo_q[31];
  assign b_neg     = is_signed & dvs_q[31];

  // The add/sub unit is only borrowed during ITER; otherwise drive zeros.
  always_comb begin
    au_a  = 32'd0;
    au_b  = 32'd0;
    au_as = 1'b0;
    if (state_q == S_ITER) begin
      au_a  = rem_shift;
      au_b  = dvs_q;
      au_as = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    count_d   = count_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_PREP;
          op_d    = op;
          // Raw operands parked in the working registers until PREP.
          quo_d   = rs1;
          dvs_d   = rs2;
        end
      end

      S_PREP: begin
        quo_neg_d = a_neg ^ b_neg;
        rem_neg_d = a_neg;
        quo_d     = a_neg ? (32'd0 - quo_q) : quo_q;
        dvs_d     = b_neg ? (32'd0 - dvs_q) : dvs_q;
        rem_d     = 32'd0;
        count_d   = 5'd0;
        if (dvs_q == 32'd0) begin
          result_d = op_q[1] ? quo_q : 32'hFFFF_FFFF;
          state_d  = S_DONE;
        end else if (is_signed && (quo_q == C_INT_MIN) && (dvs_q == 32'hFFFF_FFFF)) begin
          result_d = op_q[1] ? 32'd0 : C_INT_MIN;
          state_d  = S_DONE;
        end else begin
          state_d  = S_ITER;
        end
      end

      S_ITER: begin
        if (take) begin
          rem_d = au_s;
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[30:0], 1'b0};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (op_q[1]) begin
          result_d = rem_neg_q ? (32'd0 - rem_q) : rem_q;
        end else begin
          result_d = quo_neg_q ? (32'd0 - quo_q) : quo_q;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: back to IDLE without touching the architectural result.
    if (flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    // Status outputs are registered from the next state.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 2'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dvs_q     <= 32'd0;
      count_q   <= 5'd0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      count_q   <= count_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU that time-shares the execute-stage 32-bit add/subtract unit. It performs restoring division, one quotient bit per cycle, by driving the add/subtract unit's operand and mode inputs and sampling its sum and carry-out. It sits beside the EX stage and holds the pipeline via `busy` until `done`.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: funct3[1:0]; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1` in 32: dividend, sampled with `start`.
- `rs2` in 32: divisor, sampled with `start`.
- `flush` in 1: synchronous abort from pipeline flush.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: registered; holds its value until the next accepted `start`.
- `au_a` out 32: add/sub operand A.
- `au_b` out 32: add/sub operand B.
- `au_as` out 1: add/sub mode; 1 = A−B.
- `au_s` in 32: add/sub sum.
- `au_c` in 1: add/sub carry-out; for A−B, 1 means no borrow (A ≥ B unsigned).

## Operation
- **States:** IDLE, PREP, ITER, FIX, DONE.
- **IDLE:** `start`=1 and `flush`=0 latches `op`, `rs1`, `rs2`, then goes to PREP.
- **PREP:**
  - Signed ops (op[0]=0): take |rs1| and |rs2| by internal two's-complement negation. Record `neg_q` = sign(rs1) XOR sign(rs2) and `neg_r` = sign(rs1).
  - Unsigned ops: `neg_q` = `neg_r` = 0.
  - Load Q = |dividend|, R = 0, D = |divisor|, count = 0.
  - Special cases skip ITER, load `result` directly and go to DONE:
    - rs2 = 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
    - Signed op with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: DIV → 0x80000000; REM → 0.
  - Otherwise go to ITER.
- **ITER** (32 cycles, count 0..31):
  - Shifted remainder Rs = {R[30:0], Q[31]}.
  - Drive `au_a`=Rs, `au_b`=D, `au_as`=1.
  - take = R[31] | `au_c`. R[31] carries bit 32 of the 33-bit shifted remainder, so take=1 whenever it is set.
  - take=1: R ← `au_s`, Q ← {Q[30:0],1}.
  - take=0: R ← Rs, Q ← {Q[30:0],0}.
  - After the count=31 update, go to FIX.
- **FIX:**
  - DIV/DIVU: `result` ← `neg_q` ? −Q : Q.
  - REM/REMU: `result` ← `neg_r` ? −R : R.
  - Go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Add/sub drive outside ITER:** `au_a`=0, `au_b`=0, `au_as`=0.
- **`start` while `busy`:** ignored and not queued.
- **`flush`:** in any non-IDLE state, next state is IDLE, no `done`, `result` unchanged. In IDLE with `start` also high, `flush` wins and nothing is accepted.
- **Reset (`rst_n`=0 at a rising edge):** state IDLE, `busy`=0, `done`=0, `result`=0, Q/R/D/count=0. `au_a`/`au_b`/`au_as` are 0. Reset mid-operation behaves the same; no `done` follows.

## Timing
- Edge E0 samples `start`, so PREP is the cycle after E0.
- **Normal path:** ITER occupies cycles 2..33 after E0, FIX cycle 34, DONE cycle 35. `done` rises 35 cycles after the `start` edge.
- **Special case:** PREP is followed by DONE, so `done` rises 2 cycles after the `start` edge.
- `busy` rises the cycle after E0 and stays high through the DONE cycle. The earliest new `start` is sampled at the edge ending DONE+1 (IDLE).
- `result` changes only at the edge entering DONE (special case) or the edge entering DONE from FIX. It is stable during and after `done`.
- The add/sub path is purely combinational: `au_s`/`au_c` are sampled at the same edge on which `au_a`/`au_b` are driven; there is no add/sub latency.

## Test plan
- DIVU rs1=100, rs2=7 → `done` 35 cycles after `start`, `result`=14. Repeat as REMU → 2.
- REM rs1=0xFFFFFFF9 (−7), rs2=2 → `result`=0xFFFFFFFF. DIV with the same operands → 0xFFFFFFFD.
- DIVU rs1=0xFFFFFFFF, rs2=0x80000001 → 1. REMU with the same operands → 0x7FFFFFFE. This exercises the R[31] take path.
- Special cases, each with `done` 2 cycles after `start`:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
- Assert `flush` at ITER count=10 → IDLE next cycle, no `done`, `result` unchanged. An immediate new DIVU 9/3 then returns 3 after 35 cycles.
- `start` pulses while `busy` with different operands → ignored; the first result is unchanged. `rst_n`=0 mid-ITER → all outputs 0 next cycle and no `done` follows.
